// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: instruction and data ports arbitrated onto one shared byte-masked RAM.
// Define UMC_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port has fixed priority.
module unified_mem_ctrl #(
  parameter int DataWidth = 32,
  parameter int Address   = 8,
  parameter int Latency   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_request,
  input  logic                   if_we_re,
  input  logic [DataWidth/8-1:0] if_mask,
  input  logic [Address-1:0]     if_address,
  input  logic [DataWidth-1:0]   if_data_in,
  output logic                   if_valid,
  output logic [DataWidth-1:0]   if_data_out,
  input  logic                   dm_request,
  input  logic                   dm_we_re,
  input  logic [DataWidth/8-1:0] dm_mask,
  input  logic [Address-1:0]     dm_address,
  input  logic [DataWidth-1:0]   dm_data_in,
  output logic                   dm_valid,
  output logic [DataWidth-1:0]   dm_data_out,
  output logic                   busy
);
  localparam int NB = DataWidth / 8;
  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_gnt_dm;
  logic                 r_we;
  logic [NB-1:0]        r_mask;
  logic [Address-1:0]   r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [DataWidth-1:0] r_mem [2**Address];

  logic w_pick_dm;
  logic w_done;

`ifdef UMC_ROUND_ROBIN_EN
  // Pointer remembers the last granted port; reset value "instruction" hands the first tie to data.
  logic r_last_dm;

  always_comb begin
    w_pick_dm = dm_request;
    if (dm_request && if_request) w_pick_dm = !r_last_dm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last_dm <= 1'b0;
    else if (r_state == IDLE && (if_request || dm_request))
      r_last_dm <= w_pick_dm;
  end
`else
  assign w_pick_dm = dm_request;
`endif

  assign w_done = (r_state == ACCESS) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_gnt_dm    <= 1'b0;
      r_we        <= 1'b0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      if_valid    <= 1'b0;
      dm_valid    <= 1'b0;
      busy        <= 1'b0;
      if_data_out <= '0;
      dm_data_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (if_request || dm_request) begin
            r_gnt_dm <= w_pick_dm;
            r_we     <= w_pick_dm ? dm_we_re   : if_we_re;
            r_mask   <= w_pick_dm ? dm_mask    : if_mask;
            r_addr   <= w_pick_dm ? dm_address : if_address;
            r_wdata  <= w_pick_dm ? dm_data_in : if_data_in;
            r_cnt    <= CW'(Latency - 1);
            busy     <= 1'b1;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            if (r_gnt_dm) dm_valid <= 1'b1;
            else          if_valid <= 1'b1;
            // Writes leave data_out holding the last read value.
            if (!r_we) begin
              if (r_gnt_dm) dm_data_out <= r_mem[r_addr];
              else          if_data_out <= r_mem[r_addr];
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array is deliberately not reset; an aborted transfer never reaches w_done.
  always_ff @(posedge clk) begin
    if (w_done && r_we) begin
      for (int b = 0; b < NB; b++)
        if (r_mask[b]) r_mem[r_addr][b*8 +: 8] <= r_wdata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench: three controllers (Latency 2, 1, 8) checked with immediate assertions.
module tb_unified_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        if_req [3], if_we [3], dm_req [3], dm_we [3];
  logic [3:0]  if_mask[3], dm_mask[3];
  logic [7:0]  if_addr[3], dm_addr[3];
  logic [31:0] if_din [3], dm_din [3], if_dout[3], dm_dout[3];
  logic        if_vld [3], dm_vld [3], bsy [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unified_mem_ctrl #(
      .DataWidth(32), .Address(8), .Latency(g == 1 ? 1 : (g == 2 ? 8 : 2))
    ) u_dut (
      .clk(clk), .rst(rst_n),
      .if_request(if_req[g]), .if_we_re(if_we[g]), .if_mask(if_mask[g]),
      .if_address(if_addr[g]), .if_data_in(if_din[g]),
      .if_valid(if_vld[g]), .if_data_out(if_dout[g]),
      .dm_request(dm_req[g]), .dm_we_re(dm_we[g]), .dm_mask(dm_mask[g]),
      .dm_address(dm_addr[g]), .dm_data_in(dm_din[g]),
      .dm_valid(dm_vld[g]), .dm_data_out(dm_dout[g]),
      .busy(bsy[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 8 : 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One handshake; valid must be seen at the (Latency+1)th edge after the sampling edge.
  // Operands are scrambled after the sampling edge to prove they were latched.
  task automatic xfer(input int k, input bit dm, input bit we, input logic [3:0] m,
                      input logic [7:0] a, input logic [31:0] d, input string tag);
    int  n = 0;
    logic v;
    @(negedge clk);
    if (dm) begin dm_req[k] = 1; dm_we[k] = we; dm_mask[k] = m; dm_addr[k] = a; dm_din[k] = d; end
    else    begin if_req[k] = 1; if_we[k] = we; if_mask[k] = m; if_addr[k] = a; if_din[k] = d; end
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (dm) begin dm_addr[k] = ~a; dm_din[k] = ~d; dm_mask[k] = ~m; end
        else    begin if_addr[k] = ~a; if_din[k] = ~d; if_mask[k] = ~m; end
      end
      v = dm ? dm_vld[k] : if_vld[k];
    end while (!v && n < 40);
    chk({tag, " latency"}, 32'(n), 32'(lat_of(k) + 1));
    chk({tag, " other valid"}, 32'(dm ? if_vld[k] : dm_vld[k]), 32'd0);
    if (dm) dm_req[k] = 0; else if_req[k] = 0;
    @(negedge clk);
    chk({tag, " one-cycle valid"}, 32'(dm ? dm_vld[k] : if_vld[k]), 32'd0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 0; if_we[k] = 0; if_mask[k] = 0; if_addr[k] = 0; if_din[k] = 0;
      dm_req[k] = 0; dm_we[k] = 0; dm_mask[k] = 0; dm_addr[k] = 0; dm_din[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset busy",     32'(bsy[0]),    32'd0);
    chk("reset if_valid", 32'(if_vld[0]), 32'd0);
    chk("reset dm_valid", 32'(dm_vld[0]), 32'd0);
    chk("reset if_dout",  if_dout[0],     32'd0);
    chk("reset dm_dout",  dm_dout[0],     32'd0);
    rst_n = 1'b1;

    // Full write then read back
    xfer(0, 1, 1, 4'b1111, 8'd5, 32'hDEADBEEF, "wr5");
    xfer(0, 1, 0, 4'b0000, 8'd5, 32'h0, "rd5");
    chk("rd5 data", dm_dout[0], 32'hDEADBEEF);

    // Partial write, bytes 0 and 2
    xfer(0, 1, 1, 4'b0101, 8'd5, 32'h11223344, "pwr5");
    chk("dout held over write", dm_dout[0], 32'hDEADBEEF);
    xfer(0, 1, 0, 4'b0000, 8'd5, 32'h0, "prd5");
    chk("prd5 data", dm_dout[0], 32'hDE22BE44);

    // Zero-mask write is a no-op that still completes
    xfer(0, 1, 1, 4'b1111, 8'd7, 32'hCAFEF00D, "wr7");
    xfer(0, 1, 1, 4'b0000, 8'd7, 32'h12345678, "zwr7");
    chk("dout held over zero write", dm_dout[0], 32'hDE22BE44);
    xfer(0, 0, 0, 4'b0000, 8'd7, 32'h0, "ifrd7");
    chk("ifrd7 data", if_dout[0], 32'hCAFEF00D);
    chk("dm dout untouched by if", dm_dout[0], 32'hDE22BE44);

    // Simultaneous reads: data port wins each tie in both arbitration modes here
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 8'd7;
      if_req[0] = 1; if_we[0] = 0; if_addr[0] = 8'd5;
      n = 0;
      do begin @(negedge clk); n++; end while (!dm_vld[0] && !if_vld[0] && n < 40);
      chk("arb first grant dm", {30'd0, dm_vld[0], if_vld[0]}, 32'd2);
      dm_req[0] = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_vld[0] && n < 40);
      chk("arb second grant if", {30'd0, dm_vld[0], if_vld[0]}, 32'd1);
      if_req[0] = 0;
      chk("arb dm data", dm_dout[0], 32'hCAFEF00D);
      chk("arb if data", if_dout[0], 32'hDE22BE44);
    end

    // Reset during ACCESS aborts the write
    xfer(0, 1, 1, 4'b1111, 8'd9, 32'h0, "wr9 zero");
    @(negedge clk);
    dm_req[0] = 1; dm_we[0] = 1; dm_mask[0] = 4'b1111; dm_addr[0] = 8'd9; dm_din[0] = 32'h55AA55AA;
    @(negedge clk);
    chk("busy in access", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy",     32'(bsy[0]),    32'd0);
    chk("abort dm_valid", 32'(dm_vld[0]), 32'd0);
    chk("abort if_valid", 32'(if_vld[0]), 32'd0);
    chk("abort dm_dout",  dm_dout[0],     32'd0);
    chk("abort if_dout",  if_dout[0],     32'd0);
    dm_req[0] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1, 0, 4'b0000, 8'd9, 32'h0, "rd9");
    chk("rd9 data", dm_dout[0], 32'h0);

    // Latency 1 and 8 builds: preload then back-to-back instruction reads
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 4; i++)
        xfer(k, 1, 1, 4'b1111, 8'(i), 32'h10203040 + 32'(i) * 32'h01010101, "preload");
      for (int i = 0; i < 4; i++) begin
        xfer(k, 0, 0, 4'b0000, 8'(i), 32'h0, "lat ifrd");
        chk("lat ifrd data", if_dout[k], 32'h10203040 + 32'(i) * 32'h01010101);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
